// File: rtl/rv32_pkg.sv
// Shared RV32 decode-stage definitions: datapath width, JAL opcode and the
// state encoding used by the jump sequencer.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    REDIR = 2'd2,
    WB    = 2'd3
  } jal_state_t;

endpackage

// File: rtl/j_offset_gen.sv
// Reassembles the scrambled J-type immediate (instr[31:12]) into the
// sign-extended byte offset of a JAL. Purely combinational so the branch
// predictor can share it.
module j_offset_gen
  import rv32_pkg::*;
(
  input  logic [19:0]     imm_field,  // instr[31:12]
  output logic [XLEN-1:0] offset
);

  // Field layout: imm_field[19]=imm[20], [18:9]=imm[10:1], [8]=imm[11], [7:0]=imm[19:12]
  always_comb begin
    offset = {{11{imm_field[19]}}, imm_field[19], imm_field[7:0],
              imm_field[8], imm_field[18:9], 1'b0};
  end

endmodule

// File: rtl/jal_sequencer.sv
// Multi-cycle JAL executor: accepts one J-type instruction with its PC,
// computes target and link, then issues a fetch redirect followed by a
// link-register write, each over its own valid/ready handshake.
module jal_sequencer
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_exc,
  output logic            illegal_exc,
  output logic            busy
);

  jal_state_t      state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] link_q, link_d;
  logic            misalign_q, misalign_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] offset_s;
  logic [XLEN-1:0] calc_target_s;
  logic [4:0]      rd_s;

  j_offset_gen u_j_offset_gen (
    .imm_field (instr_q[31:12]),
    .offset    (offset_s)
  );

  assign calc_target_s = pc_q + offset_s;
  assign rd_s          = instr_q[11:7];

  // Next-state, operand capture and exception pulse generation; flush wins over everything
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    target_d   = target_q;
    link_d     = link_q;
    misalign_d = 1'b0;
    illegal_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            instr_d = instr;
            pc_d    = pc;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          target_d = calc_target_s;
          link_d   = pc_q + 32'd4;
          if (instr_q[6:0] != OPC_JAL) begin
            illegal_d = 1'b1;
            state_d   = IDLE;
          end else if (calc_target_s[1]) begin
            misalign_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = REDIR;
          end
        end
        REDIR: begin
          if (redir_ready) begin
            state_d = (rd_s != 5'd0) ? WB : IDLE;
          end else begin
            state_d = REDIR;
          end
        end
        WB: begin
          if (wb_ready) begin
            state_d = IDLE;
          end else begin
            state_d = WB;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset to a quiet idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instr_q    <= 32'd0;
      pc_q       <= 32'd0;
      target_q   <= 32'd0;
      link_q     <= 32'd0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      link_q     <= link_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
    end
  end

  // Outputs come only from registers or decoded state, never from live inputs;
  // payloads are gated by their valid so an idle or reset block shows zeros
  always_comb begin
    in_ready     = (state_q == IDLE);
    busy         = (state_q != IDLE);
    redir_valid  = (state_q == REDIR);
    wb_valid     = (state_q == WB);
    redir_pc     = (state_q == REDIR) ? target_q : 32'd0;
    wb_rd        = (state_q == WB) ? rd_s : 5'd0;
    wb_data      = (state_q == WB) ? link_q : 32'd0;
    misalign_exc = misalign_q;
    illegal_exc  = illegal_q;
  end

endmodule

// File: tb/tb_jal_sequencer.sv
// Directed bench for jal_sequencer with a handshake scoreboard.
module tb_jal_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_i = 32'd0;
  logic [31:0] pc_i = 32'd0;
  logic        flush = 1'b0;
  logic        redir_valid;
  logic        redir_ready = 1'b1;
  logic [31:0] redir_pc;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_exc;
  logic        illegal_exc;
  logic        busy;

  int n_checks = 0;
  int n_err = 0;
  int redir_hs = 0;
  int wb_hs = 0;
  int redir_hs0;
  int wb_hs0;
  logic [31:0] exp_redir_q[$];
  logic [36:0] exp_wb_q[$];
  logic [31:0] held_pc;

  jal_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr_i),
    .pc           (pc_i),
    .flush        (flush),
    .redir_valid  (redir_valid),
    .redir_ready  (redir_ready),
    .redir_pc     (redir_pc),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_exc (misalign_exc),
    .illegal_exc  (illegal_exc),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer one instruction at a negedge; returns at the negedge of cycle 1 (CALC)
  task automatic accept(input logic [31:0] i, input logic [31:0] p);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    instr_i  = i;
    pc_i     = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard: every completed handshake pops and compares the expected payload
  always @(posedge clk) begin
    if (rst_n && redir_valid && redir_ready) begin
      redir_hs <= redir_hs + 1;
      if (exp_redir_q.size() > 0) begin
        chk("sb_redir_pc", {32'd0, redir_pc}, {32'd0, exp_redir_q.pop_front()});
      end else begin
        chk("sb_unexpected_redir", 64'd1, 64'd0);
      end
    end
    if (rst_n && wb_valid && wb_ready) begin
      wb_hs <= wb_hs + 1;
      if (exp_wb_q.size() > 0) begin
        chk("sb_wb_rd_data", {27'd0, wb_rd, wb_data}, {27'd0, exp_wb_q.pop_front()});
      end else begin
        chk("sb_unexpected_wb", 64'd1, 64'd0);
      end
    end
  end

  initial begin
    // Reset values
    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_valids_busy", {59'd0, redir_valid, wb_valid, misalign_exc, illegal_exc, busy}, 64'd0);
    chk("rst_payload", {redir_pc, wb_data}, 64'd0);
    chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // JAL x1,+8 at 0x100
    exp_redir_q.push_back(32'h0000_0108);
    exp_wb_q.push_back({5'd1, 32'h0000_0104});
    accept(32'h008000EF, 32'h0000_0100);
    chk("t1_c1_busy", {62'd0, busy, redir_valid}, 64'd2);
    tick();
    chk("t1_c2_redir", {31'd0, redir_valid, redir_pc}, {31'd0, 1'b1, 32'h108});
    tick();
    chk("t1_c3_wb", {26'd0, wb_valid, wb_rd, wb_data}, {26'd0, 1'b1, 5'd1, 32'h104});
    chk("t1_c3_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("t1_c4_idle", {62'd0, in_ready, wb_valid}, 64'd2);

    // JAL x0,-4 at 0x200: no link write
    exp_redir_q.push_back(32'h0000_01FC);
    accept(32'hFFDFF06F, 32'h0000_0200);
    tick();
    chk("t2_c2_redir", {31'd0, redir_valid, redir_pc}, {31'd0, 1'b1, 32'h1FC});
    tick();
    chk("t2_c3_idle_no_wb", {62'd0, in_ready, wb_valid}, 64'd2);

    // Misaligned target (+2)
    accept(32'h002000EF, 32'h0000_0100);
    tick();
    chk("t3_misalign_pulse", {60'd0, misalign_exc, illegal_exc, in_ready, redir_valid}, 64'b1010);
    tick();
    chk("t3_misalign_end", {61'd0, misalign_exc, redir_valid, wb_valid}, 64'd0);

    // Illegal opcode (ADDI)
    accept(32'h00000013, 32'h0000_0100);
    tick();
    chk("t4_illegal_pulse", {60'd0, misalign_exc, illegal_exc, in_ready, redir_valid}, 64'b0110);
    tick();
    chk("t4_illegal_end", {62'd0, illegal_exc, redir_valid}, 64'd0);

    // Address wrap
    exp_redir_q.push_back(32'h0000_0004);
    exp_wb_q.push_back({5'd1, 32'h0000_0000});
    accept(32'h008000EF, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap_redir", {32'd0, redir_pc}, 64'h4);
    tick();
    chk("t5_wrap_wb", {31'd0, wb_valid, wb_data}, {31'd0, 1'b1, 32'h0});
    tick();

    // Backpressure on both handshakes
    redir_hs0 = redir_hs;
    wb_hs0 = wb_hs;
    redir_ready = 1'b0;
    wb_ready = 1'b0;
    exp_redir_q.push_back(32'h0000_0508);
    exp_wb_q.push_back({5'd1, 32'h0000_0504});
    accept(32'h008000EF, 32'h0000_0500);
    tick();
    held_pc = redir_pc;
    for (int i = 0; i < 5; i++) begin
      chk("t6_redir_hold", {31'd0, redir_valid, redir_pc}, {31'd0, 1'b1, 32'h508});
      tick();
    end
    redir_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t6_wb_hold", {26'd0, wb_valid, wb_rd, wb_data}, {26'd0, 1'b1, 5'd1, 32'h504});
      tick();
    end
    wb_ready = 1'b1;
    tick();
    chk("t6_idle", {63'd0, in_ready}, 64'd1);
    chk("t6_one_redir_hs", redir_hs - redir_hs0, 64'd1);
    chk("t6_one_wb_hs", wb_hs - wb_hs0, 64'd1);

    // Flush while in WB
    wb_ready = 1'b0;
    exp_redir_q.push_back(32'h0000_0108);
    accept(32'h008000EF, 32'h0000_0100);
    tick();
    tick();
    chk("t7_in_wb", {63'd0, wb_valid}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t7_flushed", {61'd0, wb_valid, in_ready, busy}, 64'b010);
    wb_ready = 1'b1;

    // Flush coinciding with in_valid blocks acceptance
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("t8_flush_blocks_accept", {62'd0, busy, in_ready}, 64'd1);
    tick();
    chk("t8_still_idle", {62'd0, busy, redir_valid}, 64'd0);

    // Asynchronous reset while in REDIR discards the transfer
    redir_ready = 1'b0;
    accept(32'h008000EF, 32'h0000_0300);
    tick();
    chk("t9_in_redir", {63'd0, redir_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t9_rst_valids", {59'd0, redir_valid, wb_valid, misalign_exc, illegal_exc, busy}, 64'd0);
    chk("t9_rst_payload", {redir_pc, wb_data}, 64'd0);
    chk("t9_rst_in_ready", {58'd0, in_ready, wb_rd}, {58'd0, 1'b1, 5'd0});
    tick();
    rst_n = 1'b1;
    redir_ready = 1'b1;
    tick();

    chk("sb_redir_drained", exp_redir_q.size(), 64'd0);
    chk("sb_wb_drained", exp_wb_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/jal_sequencer.md
# jal_sequencer

Multi-cycle controller that executes RV32I JAL instructions handed over by the fetch/decode stage. It takes a J-type instruction word plus its PC, reassembles the scrambled 20-bit J immediate, and computes the jump target and link value. It then issues a PC redirect to fetch and a link-register write to the register file, each over its own valid/ready handshake. It sits beside the J-type field decoder in the decode stage and owns all sequencing for jumps.

## Interface
- XLEN, 32, datapath width; only 32 supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction/PC offered.
- in_ready  out  1  block can accept; high only in IDLE.
- instr  in  32  instruction word; opcode instr[6:0], rd instr[11:7], imm field instr[31:12].
- pc  in  XLEN  address of instr.
- flush  in  1  synchronous abort; highest priority.
- redir_valid  out  1  redirect pending.
- redir_ready  in  1  fetch accepts redirect.
- redir_pc  out  XLEN  jump target.
- wb_valid  out  1  link write pending.
- wb_ready  in  1  register file accepts write.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  link value.
- misalign_exc  out  1  one-cycle pulse: target not 4-byte aligned.
- illegal_exc  out  1  one-cycle pulse: accepted opcode is not 7'b1101111.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, REDIR, WB.
- IDLE: in_ready=1. On in_valid && !flush, register instr/pc, go to CALC.
- CALC: offset = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}) to 32 bits. Register target = pc + offset and link = pc + 4, both mod 2^32 (silent wrap). Then:
  - opcode != 1101111: pulse illegal_exc, go to IDLE.
  - target[1] = 1: pulse misalign_exc, go to IDLE. No redirect and no write.
  - otherwise go to REDIR.
- REDIR: redir_valid=1, redir_pc=target, held stable until redir_ready. On the handshake, go to WB if rd != 0, else IDLE.
- WB: wb_valid=1, wb_rd=rd, wb_data=link, held stable until wb_ready. On the handshake, go to IDLE.
- flush in any state: next state IDLE and all valids/pulses deassert next cycle. A flush in the same cycle as in_valid blocks acceptance. A flush coinciding with a redir/wb handshake: the transfer counts, and the state still goes to IDLE.
- Only one instruction in flight; no queueing.

## Timing
- Reset: state IDLE; in_ready=1; redir_valid, wb_valid, misalign_exc, illegal_exc, busy = 0; redir_pc, wb_rd, wb_data = 0.
- All outputs come from registers or from state only. No combinational path from in_valid/redir_ready/wb_ready to any output.
- Accept at edge E0 → CALC in cycle 1 → redir_valid high in cycle 2.
- With ready held high: wb_valid in cycle 3, in_ready in cycle 4 (4-cycle throughput). With rd=0, in_ready returns in cycle 3.
- Exception pulses: high for exactly the cycle after CALC; in_ready is high in that same cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously). Any half-finished transfer is discarded.

## Structure
- Shared package `rv32_pkg`:
  - OPC_JAL = 7'b1101111.
  - jal_state_t enum {IDLE, CALC, REDIR, WB}.
  - XLEN constant.
- Sub-module `j_offset_gen`: purely combinational. Maps instr[31:12] to the sign-extended 32-bit JAL offset. Reused by the branch predictor.
- The FSM, the target/link registers and the two handshakes live in jal_sequencer.

## Test plan
- instr=0x008000EF (JAL x1,+8), pc=0x100, readies high → redir_pc=0x108 in cycle 2; wb_rd=1, wb_data=0x104 in cycle 3; in_ready in cycle 4.
- instr=0xFFDFF06F (JAL x0,−4), pc=0x200 → redir_pc=0x1FC; no wb_valid; in_ready in cycle 3.
- instr=0x002000EF (offset +2), pc=0x100 → misalign_exc one cycle; no redir_valid or wb_valid. instr=0x00000013 → illegal_exc one cycle.
- pc=0xFFFFFFFC, instr=0x008000EF → redir_pc=0x00000004, wb_data=0x00000000.
- redir_ready low for 5 cycles, then high → redir_valid/redir_pc stable all 5 cycles, and exactly one handshake. Same check for wb_ready.
- flush asserted while in WB → wb_valid low next cycle, then IDLE. rst_n pulsed low in REDIR → redir_valid drops immediately, and all outputs take their reset values.
